// File: rtl/bin2ascii_pkg.sv
// Shared types and constants for the binary-to-decimal-ASCII streamer.
package bin2ascii_pkg;

  typedef enum logic [2:0] {IDLE, CONV, SIGN, EMIT, TERM} state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  // Decimal digits needed to hold the largest unsigned value of a given width.
  function automatic int min_digits(input int width);
    longint unsigned maxv;
    longint unsigned p;
    int d;
    maxv = (64'd1 << width) - 64'd1;
    d = 1;
    p = 64'd10;
    for (int i = 0; i < 20; i++) begin
      if (p <= maxv) begin
        d++;
        p = p * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Iterative shift-and-add-3 converter: done pulses DATA_WIDTH+1 cycles after start.
// bcd holds the result until the next start; no backpressure (caller waits for done).
module bcd_dabble_core #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     bin,
  output logic                      done,
  output logic [4*NUM_DIGITS-1:0]   bcd
);
  localparam int BW = 4*NUM_DIGITS;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  running;
  logic [BW-1:0]         adj;

  // Per-nibble correction; no carry crosses a nibble boundary.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg   <= bin;
        bcd     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        bcd   <= {adj[BW-2:0], shreg[DATA_WIDTH-1]};
        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(DATA_WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bin2ascii_stream.sv
// Converts one binary word to an ASCII decimal byte stream ('-', digits, terminator).
// First byte DATA_WIDTH+1 cycles after accept; out bytes hold until out_ready, no new word until done.
module bin2ascii_stream
  import bin2ascii_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         NUM_DIGITS = 5,
  parameter int         SIGNED_EN  = 0,
  parameter int         TERM_EN    = 1,
  parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  lz_suppress,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int BW = 4*NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < min_digits(DATA_WIDTH)) begin : g_digits_check
    $error("NUM_DIGITS too small for DATA_WIDTH");
  end

  state_t                state;
  logic                  neg;
  logic                  lz;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         lead;
  logic [IW-1:0]         first_idx;
  logic                  start;
  logic                  done;
  logic                  xfer;
  logic                  in_neg;
  logic [DATA_WIDTH-1:0] mag;
  logic [BW-1:0]         bcd;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign start    = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign in_neg   = (SIGNED_EN != 0) && in_data[DATA_WIDTH-1];
  assign mag      = in_neg ? -in_data : in_data;

  bcd_dabble_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (mag),
    .done  (done),
    .bcd   (bcd)
  );

  // Highest nonzero digit; an all-zero value still emits digit 0.
  always_comb begin
    lead = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) lead = IW'(i);
    end
    first_idx = lz ? lead : IW'(NUM_DIGITS - 1);
  end

  function automatic logic [7:0] ascii_of(input logic [BW-1:0] b, input logic [IW-1:0] i);
    return ASCII_ZERO + {4'd0, b[4*i +: 4]};
  endfunction

  function automatic logic last_of(input logic [IW-1:0] i);
    return (TERM_EN == 0) && (i == '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      neg       <= 1'b0;
      lz        <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            neg   <= in_neg;
            lz    <= lz_suppress;
            state <= CONV;
          end
        end
        CONV: begin
          if (done) begin
            idx       <= first_idx;
            out_valid <= 1'b1;
            if (neg) begin
              state    <= SIGN;
              out_data <= ASCII_MINUS;
              out_last <= 1'b0;
            end else begin
              state    <= EMIT;
              out_data <= ascii_of(bcd, first_idx);
              out_last <= last_of(first_idx);
            end
          end
        end
        SIGN: begin
          if (xfer) begin
            state    <= EMIT;
            out_data <= ascii_of(bcd, idx);
            out_last <= last_of(idx);
          end
        end
        EMIT: begin
          if (xfer) begin
            if (idx == '0) begin
              if (TERM_EN != 0) begin
                state    <= TERM;
                out_data <= TERM_CHAR;
                out_last <= 1'b1;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_data  <= 8'h00;
                out_last  <= 1'b0;
              end
            end else begin
              idx      <= idx - 1'b1;
              out_data <= ascii_of(bcd, idx - 1'b1);
              out_last <= last_of(idx - 1'b1);
            end
          end
        end
        TERM: begin
          if (xfer) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2ascii_stream.sv
// Drives three configurations (default, signed, 32-bit without terminator) against a decimal reference model.
module tb_bin2ascii_stream;

  localparam int UW [3] = '{16, 16, 32};
  localparam int USG[3] = '{0, 1, 0};
  localparam int UND[3] = '{5, 5, 10};
  localparam int UTE[3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [3];
  logic        lz [3];
  logic        out_ready [3];
  logic [31:0] in_data [3];
  logic        in_ready [3];
  logic        out_valid [3];
  logic        out_last [3];
  logic        busy [3];
  logic [7:0]  out_data [3];

  int  n_chk = 0;
  int  n_fail = 0;
  byte exp_q[$];

  always #5 clk = ~clk;

  bin2ascii_stream u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][15:0]), .lz_suppress(lz[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0])
  );

  bin2ascii_stream #(.SIGNED_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][15:0]), .lz_suppress(lz[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1])
  );

  bin2ascii_stream #(.DATA_WIDTH(32), .NUM_DIGITS(10), .TERM_EN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .lz_suppress(lz[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]), .busy(busy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: decimal digits by division, then sign/zero-strip/terminator rules.
  task automatic build(input int u, input logic [31:0] val, input bit lzs);
    longint unsigned v;
    longint unsigned mag;
    bit neg;
    byte d[$];
    v   = longint'(val) & ((64'd1 << UW[u]) - 64'd1);
    neg = (USG[u] != 0) && (v >= (64'd1 << (UW[u] - 1)));
    mag = neg ? (64'd1 << UW[u]) - v : v;
    d.delete();
    for (int i = 0; i < UND[u]; i++) begin
      d.push_front(byte'(mag % 64'd10));
      mag = mag / 64'd10;
    end
    if (lzs) while (d.size() > 1 && d[0] == 0) void'(d.pop_front());
    exp_q.delete();
    if (neg) exp_q.push_back(8'h2D);
    foreach (d[i]) exp_q.push_back(byte'(8'h30 + d[i]));
    if (UTE[u] != 0) exp_q.push_back(8'h0D);
  endtask

  task automatic run(input int u, input logic [31:0] val, input bit lzs, input bit rnd, input string tag);
    int   cyc;
    int   n;
    int   guard;
    logic v;
    logic l;
    logic pl;
    logic [7:0] d;
    logic [7:0] pd;
    bit   stalled;
    bit   rdy;
    build(u, val, lzs);
    chk({tag, " in_ready_before"}, in_ready[u], 1);
    in_valid[u]  = 1'b1;
    in_data[u]   = val;
    lz[u]        = lzs;
    out_ready[u] = 1'b0;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    cyc = 0;
    while (!out_valid[u] && cyc < 100) begin
      if (rnd) begin
        in_valid[u] = 1'($urandom_range(0, 1));
        in_data[u]  = $urandom;
        lz[u]       = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, UW[u] + 1);
    chk({tag, " busy"}, busy[u], 1);
    n = 0; guard = 0; stalled = 1'b0; pd = 8'h00; pl = 1'b0;
    while (n < exp_q.size() && guard < 400) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready[u] = rdy;
      if (rnd) begin
        in_valid[u] = 1'($urandom_range(0, 1));
        in_data[u]  = $urandom;
      end
      v = out_valid[u]; d = out_data[u]; l = out_last[u];
      if (stalled) begin
        chk({tag, " hold_valid"}, v, 1);
        chk({tag, " hold_data"}, d, pd);
        chk({tag, " hold_last"}, l, pl);
      end
      @(posedge clk); #1;
      guard++;
      if (v && rdy) begin
        chk({tag, $sformatf(" byte%0d", n)}, d, exp_q[n]);
        chk({tag, $sformatf(" last%0d", n)}, l, (n == exp_q.size() - 1));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = v; pd = d; pl = l;
      end
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    chk({tag, " byte_count"}, n, exp_q.size());
    chk({tag, " in_ready_after"}, in_ready[u], 1);
    chk({tag, " busy_after"}, busy[u], 0);
    @(posedge clk); #1;
    chk({tag, " no_extra"}, out_valid[u], 0);
    out_ready[u] = 1'b0;
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; lz[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst u%0d in_ready", i), in_ready[i], 1);
      chk($sformatf("rst u%0d out_valid", i), out_valid[i], 0);
      chk($sformatf("rst u%0d out_data", i), out_data[i], 0);
      chk($sformatf("rst u%0d out_last", i), out_last[i], 0);
      chk($sformatf("rst u%0d busy", i), busy[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, 32'd12345, 1'b1, 1'b0, "d12345");
    run(0, 32'd0, 1'b1, 1'b0, "zero_lz");
    run(0, 32'd42, 1'b0, 1'b0, "d42_nolz");
    run(0, 32'd65535, 1'b1, 1'b1, "d65535_stall");
    run(1, 32'h8000, 1'b1, 1'b0, "s8000");
    run(1, 32'hFFFF, 1'b1, 1'b0, "sFFFF");
    run(1, 32'd7, 1'b0, 1'b1, "s7_nolz");
    run(2, 32'hFFFF_FFFF, 1'b1, 1'b0, "w_max");
    run(2, 32'd0, 1'b0, 1'b0, "w_zero_nolz");
    for (int i = 0; i < 6; i++) begin
      run(0, $urandom & 32'hFFFF, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd0_%0d", i));
      run(1, $urandom & 32'hFFFF, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd1_%0d", i));
      run(2, $urandom, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd2_%0d", i));
    end

    // Reset in the middle of emitting 12345.
    in_valid[0] = 1'b1; in_data[0] = 32'd12345; lz[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    cyc = 0;
    while (!out_valid[0] && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rstmid latency", cyc, 17);
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid busy_before", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid out_valid", out_valid[0], 0);
    chk("rstmid out_data", out_data[0], 0);
    chk("rstmid out_last", out_last[0], 0);
    chk("rstmid busy", busy[0], 0);
    chk("rstmid in_ready", in_ready[0], 1);
    out_ready[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid idle_out_valid", out_valid[0], 0);
    run(0, 32'd7, 1'b1, 1'b0, "after_rst7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
